// File: rtl/onchip_mem_stream_loader_if.sv
// rtl/onchip_mem_stream_loader_if.sv - byte-stream input and RAM s1 bus bundle for the loader
interface onchip_mem_stream_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  in_valid, in_data, mem_readdata,
        output in_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output in_valid, in_data, mem_readdata,
        input  in_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_mem_stream_loader.sv
// rtl/onchip_mem_stream_loader.sv - packs a byte stream into RAM words, then verifies by checksum
module onchip_mem_stream_loader #(
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 11,
    parameter int VERIFY_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          word_count,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               checksum,
    onchip_mem_stream_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VADDR, VDATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [31:0]       vsum_q, vsum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            checksum_q <= '0;
            vsum_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            checksum_q <= checksum_d;
            vsum_q     <= vsum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Bus strobes are computed for the state being entered so that they are
    // registered outputs yet line up with the WRITE/VADDR cycles themselves.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        checksum_d = checksum_q;
        vsum_d     = vsum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d     = base_addr;
                    count_d    = word_count;
                    checksum_d = '0;
                    error_d    = 1'b0;
                    done_d     = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (word_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        busy_d  = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = base_q + word_idx_q[ADDR_W-1:0];
                        wdata_d = word_d;
                    end
                end
            end
            WRITE: begin
                checksum_d = checksum_q + wdata_q;
                word_idx_d = word_idx_q + CNT_W'(1);
                if (word_idx_d < count_q) begin
                    state_d = COLLECT;
                end else if (VERIFY_EN != 0) begin
                    state_d    = VADDR;
                    word_idx_d = '0;
                    vsum_d     = '0;
                    cs_d       = 1'b1;
                    addr_d     = base_q;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            VADDR: begin
                state_d = VDATA;
            end
            VDATA: begin
                vsum_d     = vsum_q + bus.mem_readdata;
                word_idx_d = word_idx_q + CNT_W'(1);
                if (word_idx_d < count_q) begin
                    state_d = VADDR;
                    cs_d    = 1'b1;
                    addr_d  = base_q + word_idx_d[ADDR_W-1:0];
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = (vsum_d != checksum_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready       = (state_q == COLLECT);
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = 4'b1111;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = we_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_clken      = 1'b1;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign checksum           = checksum_q;
endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// tb/tb_onchip_mem_stream_loader.sv - directed bench for the stream loader with a 1024x32 RAM model
module tb_onchip_mem_stream_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        busy, done, error;
    logic [31:0] checksum;

    onchip_mem_stream_loader_if #(.ADDR_W(10)) bus ();

    onchip_mem_stream_loader #(.ADDR_W(10), .CNT_W(11), .VERIFY_EN(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    logic        ram_clr = 1'b0;
    logic        corrupt = 1'b0;
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          cs_cnt = 0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (bus.mem_chipselect && bus.mem_write) begin
            ram[bus.mem_address] <= bus.mem_writedata;
        end
        if (bus.mem_chipselect && !bus.mem_write)
            bus.mem_readdata <= (corrupt && bus.mem_address == 10'h011) ? 32'hFFFF_FFFF
                                                                       : ram[bus.mem_address];
        if (bus.mem_chipselect) cs_cnt <= cs_cnt + 1;
        if (bus.mem_chipselect && bus.mem_write) begin
            wr_addr.push_back(bus.mem_address);
            wr_data.push_back(bus.mem_writedata);
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tx [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic clear_ram();
        ram_clr = 1'b1;
        @(negedge clk);
        ram_clr = 1'b0;
    endtask

    task automatic load(input logic [9:0] b, input logic [10:0] c, input int nbytes,
                        input bit rnd, input int gap_after, input int wb);
        pulse_start(b, c);
        for (int i = 0; i < nbytes; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (i == gap_after) begin
                repeat (20) @(negedge clk);
                chk("gap_no_write", wr_addr.size() - wb, i / 4);
            end
            send_byte(tx[i]);
        end
        wait_done();
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        chk({pfx, "_done"}, {31'd0, done}, 32'd0);
        chk({pfx, "_error"}, {31'd0, error}, 32'd0);
        chk({pfx, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({pfx, "_cs"}, {31'd0, bus.mem_chipselect}, 32'd0);
        chk({pfx, "_we"}, {31'd0, bus.mem_write}, 32'd0);
        chk({pfx, "_addr"}, {22'd0, bus.mem_address}, 32'd0);
        chk({pfx, "_wdata"}, bus.mem_writedata, 32'd0);
        chk({pfx, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        int wb;
        int cb;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        chk("byteenable", {28'd0, bus.mem_byteenable}, 32'h0000_000F);
        chk("clken", {31'd0, bus.mem_clken}, 32'd1);
        reset_n = 1'b1;
        clear_ram();

        // basic load
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        wb = wr_addr.size();
        load(10'h010, 11'd2, 8, 1'b0, -1, wb);
        chk("basic_nwr", wr_addr.size() - wb, 2);
        chk("basic_a0", {22'd0, wr_addr[wb]}, 32'h010);
        chk("basic_d0", wr_data[wb], 32'h0403_0201);
        chk("basic_a1", {22'd0, wr_addr[wb+1]}, 32'h011);
        chk("basic_d1", wr_data[wb+1], 32'h0807_0605);
        chk("basic_sum", checksum, 32'h0C0A_0806);
        chk("basic_err", {31'd0, error}, 32'd0);
        chk("basic_busy", {31'd0, busy}, 32'd0);

        // address wrap
        tx = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        wb = wr_addr.size();
        load(10'h3FF, 11'd2, 8, 1'b0, -1, wb);
        chk("wrap_a0", {22'd0, wr_addr[wb]}, 32'h3FF);
        chk("wrap_a1", {22'd0, wr_addr[wb+1]}, 32'h000);
        chk("wrap_d1", wr_data[wb+1], 32'h1817_1615);
        chk("wrap_sum", checksum, 32'h2C2A_2826);
        chk("wrap_err", {31'd0, error}, 32'd0);

        // stalled stream with a long gap mid-word
        clear_ram();
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        wb = wr_addr.size();
        load(10'h010, 11'd2, 8, 1'b1, 2, wb);
        chk("stall_nwr", wr_addr.size() - wb, 2);
        chk("stall_ram10", ram[10'h010], 32'h0403_0201);
        chk("stall_ram11", ram[10'h011], 32'h0807_0605);
        chk("stall_err", {31'd0, error}, 32'd0);

        // verify mismatch
        corrupt = 1'b1;
        load(10'h010, 11'd2, 8, 1'b0, -1, wr_addr.size());
        chk("vfail_err", {31'd0, error}, 32'd1);
        chk("vfail_sum", checksum, 32'h0C0A_0806);
        corrupt = 1'b0;

        // zero count
        cb = cs_cnt;
        pulse_start(10'h100, 11'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_sum", checksum, 32'd0);
        chk("zero_err", {31'd0, error}, 32'd0);
        repeat (3) @(negedge clk);
        chk("zero_no_cs", cs_cnt - cb, 0);

        // start while busy is ignored
        wb = wr_addr.size();
        pulse_start(10'h010, 11'd1);
        send_byte(8'h01);
        pulse_start(10'h200, 11'd3);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_done();
        chk("ign_nwr", wr_addr.size() - wb, 1);
        chk("ign_addr", {22'd0, wr_addr[wb]}, 32'h010);
        chk("ign_sum", checksum, 32'h0403_0201);

        // reset mid-load
        pulse_start(10'h020, 11'd2);
        send_byte(8'h55);
        send_byte(8'h66);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        reset_n = 1'b1;
        wb = wr_addr.size();
        pulse_start(10'h030, 11'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_done();
        chk("post_nwr", wr_addr.size() - wb, 1);
        chk("post_addr", {22'd0, wr_addr[wb]}, 32'h030);
        chk("post_data", wr_data[wb], 32'hDDCC_BBAA);
        chk("post_sum", checksum, 32'hDDCC_BBAA);
        chk("post_err", {31'd0, error}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/onchip_mem_stream_loader.md
Name: onchip_mem_stream_loader

Overview:
- Upstream master for the 1024x32 single-port on-chip RAM (s1 slave).
- Accepts a byte stream (e.g. from the UART receiver) and packs it little-endian into 32-bit words.
- Writes the words to consecutive RAM addresses, then reads them back and checks a 32-bit additive checksum.
- Used by the boot path to load program images before the processor is released from reset.

Parameters:
- ADDR_W, 10, RAM word-address width; depth is 2**ADDR_W.
- CNT_W, 11, width of word_count; must cover the value 2**ADDR_W.
- VERIFY_EN, 1, 1 = readback verify pass after the load; 0 = go straight to DONE after the last write.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; sampled only when busy=0
- base_addr  in  ADDR_W  first RAM word address
- word_count  in  CNT_W  number of words to load; 0 is legal
- in_valid  in  1  byte-stream valid
- in_ready  out  1  byte-stream ready
- in_data  in  8  stream byte
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  4  RAM byte enables; constant 4'b1111
- mem_chipselect  out  1  RAM chipselect
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable; constant 1
- mem_readdata  in  32  RAM read data; valid the cycle after the address is presented
- busy  out  1  load or verify in progress
- done  out  1  high from operation completion until the next accepted start
- error  out  1  verify mismatch; meaningful only while done=1
- checksum  out  32  running modulo-2^32 sum of the words written

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; busy, done, error, in_ready, mem_chipselect and mem_write all 0; mem_address, mem_writedata and checksum 0. Reset aborts any operation in progress, and the partially assembled word is discarded.
- All outputs are registered except in_ready, which is decoded from state (high only in COLLECT).
- States: IDLE, COLLECT, WRITE, VADDR, VDATA, DONE.
- IDLE/DONE + start:
  - Latch base_addr and word_count.
  - Clear checksum, error, done, the word index and the byte index.
  - If word_count=0, go to DONE with checksum=0 and error=0. Otherwise go to COLLECT with busy=1.
- start while busy=1 is ignored.
- COLLECT:
  - Each in_valid&in_ready cycle loads in_data into byte lane byte_idx (byte 0 = bits 7:0).
  - When the 4th byte is accepted, the next cycle is WRITE.
- WRITE, exactly one cycle:
  - mem_chipselect=1, mem_write=1.
  - mem_address = (base + word_idx) mod 2**ADDR_W; mem_writedata = assembled word.
  - checksum += word. Increment word_idx.
  - If more words remain, return to COLLECT. Otherwise go to VADDR (VERIFY_EN=1) or DONE.
- Throughput: at most 4 bytes per 5 cycles; the bubble is the WRITE cycle, where in_ready=0.
- Verify pass:
  - Reset word_idx to 0 and clear the verify sum.
  - VADDR: mem_chipselect=1, mem_write=0, address as above.
  - VDATA: capture mem_readdata into the verify sum; mem_chipselect=0. Increment word_idx; go to VADDR if words remain, else DONE.
  - Cost: 2 cycles per word.
- Entering DONE: busy=0, done=1, error=(verify sum != checksum); error=0 when VERIFY_EN=0.
- Address wrap: base+index wraps modulo 2**ADDR_W. word_count > 2**ADDR_W overwrites earlier words, and verify then flags an error.
- Arithmetic: all sums are 32-bit and overflow wraps silently.
- In IDLE and DONE: mem_chipselect=0, mem_write=0; mem_address and mem_writedata hold their last values.

Test Plan:
- Basic load: base=0x010, count=2, bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201@0x010 and 0x08070605@0x011; checksum=0x0C0A0806; done=1; error=0.
- Wrap: base=0x3FF, count=2 -> second write lands at address 0x000; verify passes.
- Stream stalls: in_valid toggling randomly, plus one gap of 20 cycles mid-word -> same RAM contents as the unstalled case; no write issued until the 4th byte.
- Verify fail: RAM model corrupts address 0x011 to 0xFFFFFFFF -> done=1, error=1.
- Zero count and ignored start: count=0 -> done the cycle after start, no chipselect asserted; a second start during a busy load is ignored.
- Reset mid-load: reset_n=0 after 2 bytes of word 1 -> all outputs at reset values; a new start with count=1, bytes AA BB CC DD -> writes 0xDDCCBBAA.
